// File: rtl/rv32i_types.sv
// Shared RV32I typedefs plus the line/burst adaptor's state encoding and beat count.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        COOL
    } lba_state_t;

    localparam int unsigned LBA_BEATS = 4;

endpackage

// File: rtl/line_burst_adaptor.sv
// Splits cache line reads/writes into fixed-length memory bursts and reassembles read lines.
// state | meaning: IDLE wait for request, READ/WRITE burst in flight, DONE resp_o pulse, COOL swallow stale request.
module line_burst_adaptor
    import rv32i_types::*;
#(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int k_w = $clog2(LBA_BEATS);
    localparam logic [k_w-1:0] k_last = k_w'(LBA_BEATS - 1);

    lba_state_t state, state_next;
    logic [k_w-1:0] k;
    rv32i_word addr_q;
    logic [LBA_BEATS-1:0][s_burst-1:0] wline_q;
    logic [LBA_BEATS-1:0][s_burst-1:0] rline_q;
    logic beat_ack;

    assign beat_ack  = resp_i && (state == READ || state == WRITE);
    assign line_o    = rline_q;
    assign address_o = {addr_q[31:5], 5'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The read line is assembled in place, so line_o only changes during read bursts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            if (state == IDLE) begin
                if (write_i) begin
                    addr_q  <= address_i;
                    wline_q <= line_i;
                end else if (read_i) begin
                    addr_q <= address_i;
                end
            end
            if (beat_ack) begin
                k <= (k == k_last) ? '0 : k + k_w'(1);
            end
            if (state == READ && resp_i) begin
                rline_q[k] <= burst_i;
            end
        end
    end

    always_comb begin
        state_next = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        burst_o    = '0;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && k == k_last) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                burst_o = wline_q[k];
                if (resp_i && k == k_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = COOL;
            end
            COOL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed and randomized line transactions checked against a memory/cache reference model.
module tb_line_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_line;

    always #5 clk = ~clk;

    line_burst_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One cache transaction: the memory side acks per pattern bit (or randomly); the
    // expected line is the beats driven by the memory model, in ack order.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [255:0] wline, input logic [255:0] rline,
                       input logic [15:0] pat, input bit use_pat,
                       input bit hold_extra, input int exp_lat);
        int  n = 0;
        int  last_ack = -1;
        bit  got = 0;
        bit  is_wr = wr;
        bit  ack;
        address_i = addr;
        line_i    = wline;
        write_i   = wr;
        read_i    = rd;
        resp_i    = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 200 && !got; c++) begin
            if (resp_o) begin
                got = 1;
                check("beats_before_resp", 32'(n), 32'd4);
                check("resp_one_after_last_beat", 32'(c), 32'(last_ack + 1));
                if (exp_lat > 0) check("resp_latency", 32'(c), 32'(exp_lat));
                check("busy_low_in_done", {read_o, write_o}, 2'b00);
                if (!is_wr) begin
                    exp_line = rline;
                    check("read_line", line_o, rline);
                end
                if (!hold_extra) begin
                    read_i  = 1'b0;
                    write_i = 1'b0;
                end
                resp_i = 1'($urandom_range(0, 1));
            end else begin
                check(is_wr ? "write_o_only" : "read_o_only", {read_o, write_o},
                      is_wr ? 2'b01 : 2'b10);
                check("address_o", address_o, {addr[31:5], 5'b0});
                if (n < 4) ack = use_pat ? (c > 16 ? 1'b1 : pat[c-1]) : ($urandom_range(0, 2) != 0);
                else ack = 1'b0;
                if (ack) begin
                    if (is_wr) check("burst_o_beat", burst_o, wline[n*64 +: 64]);
                    else burst_i = rline[n*64 +: 64];
                    n++;
                    last_ack = c;
                end else begin
                    burst_i = {$urandom, $urandom};
                end
                resp_i = ack;
                @(negedge clk);
            end
        end
        check("resp_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("cool_quiet", {read_o, write_o, resp_o}, 3'b000);
        check("line_o_held", line_o, exp_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_quiet", {read_o, write_o, resp_o}, 3'b000);
        resp_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l1, wl, rl;
        rst = 1'b0;
        line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
        exp_line = '0;
        #1;
        check("reset_outputs", {read_o, write_o, resp_o, address_o, burst_o}, '0);
        check("reset_line_o", line_o, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Basic read: first request on the first edge after reset release.
        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        txn(0, 1, 32'h0000_1234, '0, l1, 16'hFFFF, 1, 0, 5);

        // Write with beat index in top byte; line_o must keep the read line.
        for (int b = 0; b < 4; b++) wl[b*64 +: 64] = {8'(b), 56'hADBEEF_DEADBEEF};
        txn(1, 0, 32'h8000_0040, wl, '0, 16'hFFFF, 1, 0, 5);

        // Stalled read, ack pattern 1,0,0,1,1,0,1.
        rl = rand_line();
        txn(0, 1, 32'h0000_0ABC, '0, rl, 16'h0059, 1, 0, 8);

        // Both requests high: write wins.
        wl = rand_line();
        txn(1, 1, 32'h1234_5678, wl, '0, 16'hFFFF, 1, 0, 5);

        // Read held one cycle past resp_o: cooldown must swallow it.
        rl = rand_line();
        txn(0, 1, 32'h0000_2000, '0, rl, 16'hFFFF, 1, 1, 5);

        // Reset in the middle of a read burst after two beats.
        address_i = 32'h0000_3000;
        read_i = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            check("pre_reset_read_o", 32'(read_o), 32'd1);
            burst_i = {$urandom, $urandom};
            resp_i = 1'b1;
            @(negedge clk);
        end
        resp_i = 1'b0;
        rst = 1'b0;
        #1;
        exp_line = '0;
        check("midburst_reset_outputs", {read_o, write_o, resp_o, address_o, burst_o}, '0);
        check("midburst_reset_line", line_o, '0);
        read_i = 1'b0;
        @(negedge clk);
        check("no_resp_after_reset", 32'(resp_o), 32'd0);
        rst = 1'b1;
        rl = rand_line();
        txn(0, 1, 32'h0000_3000, '0, rl, 16'hFFFF, 1, 0, 5);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(w, r, $urandom, rand_line(), rand_line(), 16'h0, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256, cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64, memory beat width in bits; beats = s_line/s_burst = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port line_i  input  s_line  write line from the cache's pmem_wdata.
REQ-006 SHALL have port line_o  output  s_line  assembled read line to the cache's pmem_rdata.
REQ-007 SHALL have port address_i  input  32  line address from the cache's pmem_address.
REQ-008 SHALL have port read_i  input  1  line read request, level, held until resp_o.
REQ-009 SHALL have port write_i  input  1  line write request, level, held until resp_o.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 SHALL have port burst_i  input  s_burst  read beat data from memory.
REQ-012 SHALL have port burst_o  output  s_burst  write beat data to memory.
REQ-013 SHALL have port address_o  output  32  burst address to memory.
REQ-014 SHALL have port read_o  output  1  burst read request to memory.
REQ-015 SHALL have port write_o  output  1  burst write request to memory.
REQ-016 SHALL have port resp_i  input  1  memory beat acknowledge, one per beat.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE, COOL.
REQ-018 In IDLE, write_i high SHALL latch address_i and line_i and go to WRITE; else read_i high SHALL latch address_i and go to READ; write has priority when both are high.
REQ-019 address_o SHALL equal the latched address with bits [4:0] cleared, stable for the whole burst.
REQ-020 READ: read_o SHALL be high; each cycle with resp_i high SHALL store burst_i into line_o[64k+63:64k] and increment 2-bit beat counter k from 0.
REQ-021 WRITE: write_o SHALL be high and burst_o SHALL equal latched line[64k+63:64k]; each resp_i high SHALL increment k.
REQ-022 Cycles with resp_i low inside a burst SHALL stall k without dropping read_o/write_o; gaps between beats are legal.
REQ-023 On the resp_i that completes beat 3, SHALL go to DONE and clear k; read_o/write_o SHALL drop in DONE.
REQ-024 DONE SHALL assert resp_o for exactly one cycle, then go to COOL.
REQ-025 COOL SHALL last one cycle, ignore read_i/write_i (covers the cache's registered request still high), then go to IDLE.
REQ-026 Minimum latency from request accept to resp_o SHALL be 5 cycles (4 beats + DONE); back-to-back requests are accepted no earlier than 2 cycles after resp_o.
REQ-027 line_o SHALL hold its last assembled value until the next read burst overwrites it; a write burst SHALL NOT alter line_o.
REQ-028 resp_i in IDLE, DONE or COOL SHALL be ignored with no state change.
REQ-029 read_o and write_o SHALL never be high in the same cycle.

Reset
REQ-030 rst low SHALL immediately force IDLE, k=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0.
REQ-031 rst asserted mid-burst SHALL abandon the burst with no resp_o; a partial line SHALL NOT be reported.
REQ-032 First request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 State enum and beat-count constant SHALL live in rv32i_types alongside existing shared typedefs.
REQ-034 SHALL be a single module with no sub-modules; parameters match the cache's s_line.

Verification
REQ-035 Read: address_i=0x0000_1234, read_i=1, memory returns beats 0x11..11,0x22..22,0x33..33,0x44..44 on 4 consecutive cycles -> address_o=0x0000_1220, resp_o on cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-036 Write: line_i=0xDEADBEEF repeated with beat index in top byte, address_i=0x8000_0040 -> write_o high, burst_o shows beats 0..3 in order, resp_o once, line_o unchanged.
REQ-037 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> four beats captured in order, resp_o 1 cycle after last beat, read_o high throughout.
REQ-038 read_i and write_i both high -> write burst performed, read_o never asserted.
REQ-039 rst low after beat 2 of a read -> outputs zero that cycle, no resp_o, next read completes normally.
REQ-040 read_i held high 1 cycle past resp_o -> no second burst started (COOL), read_o stays low.
